block_downsampler: RTL and testbench

Parametrised successor to the fixed-grid pixelate stage. Consumes the raster pixel stream from recover/bw_converter (pixel, hcount, vcount, data_valid) and reduces each BLK_W x BLK_H tile to one output sample. The reduction is selectable per frame: mean, binary threshold, max or min. Output is a tile-coordinate stream with a one-cycle valid, feeding normalize/convolution stages at any grid resolution.

---
 rtl/downsample_pkg.sv | 24 ++
 rtl/tile_reducer.sv | 48 ++++
 rtl/block_downsampler.sv | 225 ++++++++++++++++++++++
 tb/tb_block_downsampler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/downsample_pkg.sv
// -----------------------------------------------------------------------------
// downsample_pkg
//   Shared types and helpers for the block downsampler.
//   - mode_t    : per-frame reduction mode (mean / threshold / max / min)
//   - acc_width : accumulator width for a given pixel width and tile size.
//                 This is wide enough to hold the sum of a full tile without
//                 wrapping.
// -----------------------------------------------------------------------------
package downsample_pkg;

   typedef enum logic [1:0] {
      MODE_MEAN   = 2'b00,
      MODE_THRESH = 2'b01,
      MODE_MAX    = 2'b10,
      MODE_MIN    = 2'b11
   } mode_t;

   function automatic int acc_width(input int pix_w,
                                    input int blk_log2_w,
                                    input int blk_log2_h);
      return pix_w + blk_log2_w + blk_log2_h;
   endfunction

endpackage : downsample_pkg

// File: rtl/tile_reducer.sv
// -----------------------------------------------------------------------------
// tile_reducer
//   Combinational accumulate step for one tile column. At a tile origin it
//   loads the pixel and discards the old accumulator value. Otherwise it
//   folds the pixel into the accumulator according to the mode. The top level
//   uses this single result both as the write-back value and as the final
//   tile value.
//
// Ports
//   mode_i      reduction mode in effect for this pixel
//   acc_i       current accumulator value for the pixel's tile column
//   pixel_i     incoming pixel
//   origin_i    1 when the pixel is the tile's top-left pixel
//   next_acc_o  updated accumulator value
// -----------------------------------------------------------------------------
module tile_reducer
   import downsample_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int ACC_W = 14
) (
   input  mode_t              mode_i,
   input  logic [ACC_W-1:0]   acc_i,
   input  logic [PIX_W-1:0]   pixel_i,
   input  logic               origin_i,
   output logic [ACC_W-1:0]   next_acc_o
);

   logic [ACC_W-1:0] pix_ext;

   assign pix_ext = ACC_W'(pixel_i);

   // NOTE: every output of a combinational block gets a default assignment
   // first. Otherwise a path that leaves it unassigned infers a latch.
   always_comb begin
      next_acc_o = pix_ext;
      if (!origin_i) begin
         case (mode_i)
            MODE_MEAN,
            MODE_THRESH: next_acc_o = acc_i + pix_ext;
            MODE_MAX:    next_acc_o = (acc_i > pix_ext) ? acc_i : pix_ext;
            MODE_MIN:    next_acc_o = (acc_i < pix_ext) ? acc_i : pix_ext;
            default:     next_acc_o = pix_ext;
         endcase
      end
   end

endmodule : tile_reducer

// File: rtl/block_downsampler.sv
// -----------------------------------------------------------------------------
// block_downsampler
//   Reduces each (1<<BLK_LOG2_W) x (1<<BLK_LOG2_H) tile of a raster pixel
//   stream to one sample. The sample is the mean, a binary threshold of the
//   mean, the max or the min. The mode and the threshold are latched at the
//   frame origin pixel. There is one accumulator per tile column. A column's
//   accumulator is reused by every tile row, and the origin pixel of each tile
//   reloads it. The result is registered and appears one cycle after the
//   tile's bottom-right pixel.
//
// Ports
//   clk_in          system clock
//   rst_in          asynchronous active-high reset
//   hcount_in       input column
//   vcount_in       input row
//   data_valid_in   input pixel valid
//   pixel_in        input pixel
//   mode_in         00 mean, 01 threshold, 10 max, 11 min (sampled at 0,0)
//   threshold_in    threshold for mode 01 (sampled at 0,0)
//   pixel_out       reduced tile value
//   hcount_out      tile column
//   vcount_out      tile row
//   data_valid_out  one-cycle pulse per tile result
//   frame_done_out  one-cycle pulse with the last tile of the frame
// -----------------------------------------------------------------------------
module block_downsampler
   import downsample_pkg::*;
#(
   parameter int PIX_W      = 8,
   parameter int FRAME_W    = 320,
   parameter int FRAME_H    = 240,
   parameter int BLK_LOG2_W = 3,
   parameter int BLK_LOG2_H = 3
) (
   input  logic                                      clk_in,
   input  logic                                      rst_in,
   input  logic [10:0]                               hcount_in,
   input  logic [9:0]                                vcount_in,
   input  logic                                      data_valid_in,
   input  logic [PIX_W-1:0]                          pixel_in,
   input  logic [1:0]                                mode_in,
   input  logic [PIX_W-1:0]                          threshold_in,
   output logic [PIX_W-1:0]                          pixel_out,
   output logic [$clog2(FRAME_W >> BLK_LOG2_W)-1:0]  hcount_out,
   output logic [$clog2(FRAME_H >> BLK_LOG2_H)-1:0]  vcount_out,
   output logic                                      data_valid_out,
   output logic                                      frame_done_out
);

   // ---------------------------------------------------------------------------
   // Derived geometry
   // ---------------------------------------------------------------------------
   localparam int GRID_W     = FRAME_W >> BLK_LOG2_W;
   localparam int GRID_H     = FRAME_H >> BLK_LOG2_H;
   localparam int TX_W       = $clog2(GRID_W);
   localparam int TY_W       = $clog2(GRID_H);
   localparam int ACC_W      = acc_width(PIX_W, BLK_LOG2_W, BLK_LOG2_H);
   localparam int MEAN_SHIFT = BLK_LOG2_W + BLK_LOG2_H;

   localparam logic [10:0]     FRAME_W_L = 11'(FRAME_W);
   localparam logic [9:0]      FRAME_H_L = 10'(FRAME_H);
   localparam logic [TX_W-1:0] LAST_TX   = TX_W'(GRID_W - 1);
   localparam logic [TY_W-1:0] LAST_TY   = TY_W'(GRID_H - 1);

   // A partial tile at the right or bottom edge could never complete, so
   // such a geometry is rejected at elaboration.
   if ((FRAME_W % (1 << BLK_LOG2_W)) != 0 ||
       (FRAME_H % (1 << BLK_LOG2_H)) != 0) begin : g_bad_geometry
      $error("block_downsampler: frame size must be a multiple of the tile size");
   end

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [ACC_W-1:0] acc_q [GRID_W];

   mode_t            mode_q,           mode_d;
   logic [PIX_W-1:0] thresh_q,         thresh_d;
   logic [PIX_W-1:0] pixel_out_q,      pixel_out_d;
   logic [TX_W-1:0]  hcount_out_q,     hcount_out_d;
   logic [TY_W-1:0]  vcount_out_q,     vcount_out_d;
   logic             data_valid_out_q, data_valid_out_d;
   logic             frame_done_out_q, frame_done_out_d;

   // ---------------------------------------------------------------------------
   // Pixel decode
   // ---------------------------------------------------------------------------
   logic                  accept;
   logic [TX_W-1:0]       tx;
   logic [TY_W-1:0]       ty;
   logic [BLK_LOG2_W-1:0] lx;
   logic [BLK_LOG2_H-1:0] ly;
   logic                  frame_origin;
   logic                  tile_origin;
   logic                  tile_last;

   assign accept = data_valid_in &&
                   (hcount_in < FRAME_W_L) &&
                   (vcount_in < FRAME_H_L);

   // tx is only used to index acc_q when accept is high, so it is always
   // in range whenever it matters.
   assign tx = TX_W'(hcount_in >> BLK_LOG2_W);
   assign ty = TY_W'(vcount_in >> BLK_LOG2_H);
   assign lx = hcount_in[BLK_LOG2_W-1:0];
   assign ly = vcount_in[BLK_LOG2_H-1:0];

   assign frame_origin = (hcount_in == '0) && (vcount_in == '0);
   assign tile_origin  = (lx == '0) && (ly == '0);
   assign tile_last    = (&lx) && (&ly);

   // The frame-origin pixel already runs under the mode and threshold it
   // latches. For every other pixel the registered copies apply, so a change
   // on mode_in or threshold_in mid-frame has no effect.
   mode_t            mode_eff;
   logic [PIX_W-1:0] thresh_eff;

   assign mode_eff   = frame_origin ? mode_t'(mode_in) : mode_q;
   assign thresh_eff = frame_origin ? threshold_in     : thresh_q;

   // ---------------------------------------------------------------------------
   // Read-modify-write of the column accumulator
   // ---------------------------------------------------------------------------
   logic [ACC_W-1:0] acc_cur;
   logic [ACC_W-1:0] acc_next;

   assign acc_cur = acc_q[tx];

   tile_reducer #(
      .PIX_W (PIX_W),
      .ACC_W (ACC_W)
   ) u_tile_reducer (
      .mode_i     (mode_eff),
      .acc_i      (acc_cur),
      .pixel_i    (pixel_in),
      .origin_i   (tile_origin),
      .next_acc_o (acc_next)
   );

   // ---------------------------------------------------------------------------
   // Final tile value (acc_next already includes the completing pixel)
   // ---------------------------------------------------------------------------
   logic [PIX_W-1:0] mean_val;
   logic [PIX_W-1:0] reduced;

   assign mean_val = PIX_W'(acc_next >> MEAN_SHIFT);

   always_comb begin
      reduced = PIX_W'(acc_next);
      case (mode_eff)
         MODE_MEAN:   reduced = mean_val;
         MODE_THRESH: reduced = (mean_val >= thresh_eff) ? '1 : '0;
         default:     reduced = PIX_W'(acc_next);
      endcase
   end

   // ---------------------------------------------------------------------------
   // Next-state logic for control and output registers
   // ---------------------------------------------------------------------------
   always_comb begin
      mode_d           = mode_q;
      thresh_d         = thresh_q;
      pixel_out_d      = pixel_out_q;
      hcount_out_d     = hcount_out_q;
      vcount_out_d     = vcount_out_q;
      data_valid_out_d = 1'b0;
      frame_done_out_d = 1'b0;

      if (accept && frame_origin) begin
         mode_d   = mode_t'(mode_in);
         thresh_d = threshold_in;
      end

      if (accept && tile_last) begin
         pixel_out_d      = reduced;
         hcount_out_d     = tx;
         vcount_out_d     = ty;
         data_valid_out_d = 1'b1;
         frame_done_out_d = (tx == LAST_TX) && (ty == LAST_TY);
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments, so every register
   // samples its pre-edge inputs no matter what order the blocks are evaluated.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mode_q           <= MODE_MEAN;
         thresh_q         <= '0;
         pixel_out_q      <= '0;
         hcount_out_q     <= '0;
         vcount_out_q     <= '0;
         data_valid_out_q <= 1'b0;
         frame_done_out_q <= 1'b0;
      end else begin
         mode_q           <= mode_d;
         thresh_q         <= thresh_d;
         pixel_out_q      <= pixel_out_d;
         hcount_out_q     <= hcount_out_d;
         vcount_out_q     <= vcount_out_d;
         data_valid_out_q <= data_valid_out_d;
         frame_done_out_q <= frame_done_out_d;
      end
   end

   // NOTE: the accumulator array is a small flop array, not a RAM, so it is
   // given a reset. A partial tile interrupted by reset must not carry
   // stale sums forward.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         acc_q <= '{default: '0};
      end else if (accept) begin
         acc_q[tx] <= acc_next;
      end
   end

   assign pixel_out      = pixel_out_q;
   assign hcount_out     = hcount_out_q;
   assign vcount_out     = vcount_out_q;
   assign data_valid_out = data_valid_out_q;
   assign frame_done_out = frame_done_out_q;

endmodule : block_downsampler

// File: tb/tb_block_downsampler.sv
// -----------------------------------------------------------------------------
// tb_block_downsampler
//   Self-checking bench for block_downsampler with default parameters
//   (8-bit pixels, 320x240 frame, 8x8 tiles). The driver keeps a record of the
//   pixels each tile column has received since that column's last tile
//   origin. When a tile completes, the driver reduces that pixel list by the
//   frame's mode and queues the expected result. A monitor compares every
//   data_valid_out pulse with the head of that queue.
// -----------------------------------------------------------------------------
module tb_block_downsampler;

   localparam int PIX_W   = 8;
   localparam int FRAME_W = 320;
   localparam int FRAME_H = 240;
   localparam int BLK     = 8;
   localparam int GRID_W  = FRAME_W / BLK;
   localparam int GRID_H  = FRAME_H / BLK;
   localparam int NPIX    = BLK * BLK;

   logic             clk_in;
   logic             rst_in;
   logic [10:0]      hcount_in;
   logic [9:0]       vcount_in;
   logic             data_valid_in;
   logic [PIX_W-1:0] pixel_in;
   logic [1:0]       mode_in;
   logic [PIX_W-1:0] threshold_in;
   logic [PIX_W-1:0] pixel_out;
   logic [5:0]       hcount_out;
   logic [4:0]       vcount_out;
   logic             data_valid_out;
   logic             frame_done_out;

   block_downsampler dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .hcount_in      (hcount_in),
      .vcount_in      (vcount_in),
      .data_valid_in  (data_valid_in),
      .pixel_in       (pixel_in),
      .mode_in        (mode_in),
      .threshold_in   (threshold_in),
      .pixel_out      (pixel_out),
      .hcount_out     (hcount_out),
      .vcount_out     (vcount_out),
      .data_valid_out (data_valid_out),
      .frame_done_out (frame_done_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int cycle = 0;
   always @(posedge clk_in) cycle <= cycle + 1;

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int pix;
      int hx;
      int vy;
      int done;
      int cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   // ---------------------------------------------------------------------------
   // Reference model: the pixels seen per tile column, plus the frame's mode
   // ---------------------------------------------------------------------------
   int vals [GRID_W][NPIX];
   int cnt  [GRID_W];
   int m_mode = 0;
   int m_thr  = 0;

   function automatic int model_out(input int tx);
      int sum = 0;
      int mx  = 0;
      int mn  = 255;
      int mean;
      for (int k = 0; k < cnt[tx]; k++) begin
         sum += vals[tx][k];
         if (vals[tx][k] > mx) mx = vals[tx][k];
         if (vals[tx][k] < mn) mn = vals[tx][k];
      end
      mean = sum / NPIX;
      case (m_mode)
         0:       return mean;
         1:       return (mean >= m_thr) ? 255 : 0;
         2:       return mx;
         default: return mn;
      endcase
   endfunction

   // Present one pixel for exactly one clock and update the model.
   task automatic drive(input int h, input int v, input int p, input bit dv);
      int   tx, ty, lx, ly;
      exp_t e;
      @(negedge clk_in);
      hcount_in     = 11'(h);
      vcount_in     = 10'(v);
      pixel_in      = 8'(p);
      data_valid_in = dv;
      if (dv && h < FRAME_W && v < FRAME_H) begin
         tx = h / BLK;
         ty = v / BLK;
         lx = h % BLK;
         ly = v % BLK;
         if (h == 0 && v == 0) begin
            m_mode = int'(mode_in);
            m_thr  = int'(threshold_in);
         end
         if (lx == 0 && ly == 0) cnt[tx] = 0;
         if (cnt[tx] < NPIX) begin
            vals[tx][cnt[tx]] = p;
            cnt[tx]++;
         end
         if (lx == BLK - 1 && ly == BLK - 1) begin
            e.pix  = model_out(tx);
            e.hx   = tx;
            e.vy   = ty;
            e.done = (tx == GRID_W - 1 && ty == GRID_H - 1) ? 1 : 0;
            e.cyc  = cycle + 1;
            sb.push_back(e);
         end
      end
      @(posedge clk_in);
      #1 data_valid_in = 1'b0;
   endtask

   int tile_pat [NPIX];

   task automatic drive_tile(input int tx, input int ty);
      for (int ly = 0; ly < BLK; ly++)
         for (int lx = 0; lx < BLK; lx++)
            drive(tx * BLK + lx, ty * BLK + ly, tile_pat[ly * BLK + lx], 1'b1);
   endtask

   // A pixel that must be ignored: either not valid, or valid but outside
   // the active frame.
   task automatic drive_junk();
      case ($urandom_range(2))
         0:       drive($urandom_range(2047), $urandom_range(1023), $urandom_range(255), 1'b0);
         1:       drive($urandom_range(2047, FRAME_W), $urandom_range(1023), $urandom_range(255), 1'b1);
         default: drive($urandom_range(2047), $urandom_range(1023, FRAME_H), $urandom_range(255), 1'b1);
      endcase
   endtask

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (data_valid_out) begin
            if (sb.size() == 0) begin
               check("unexpected_output", int'(data_valid_out), 0);
            end else begin
               mon_e = sb.pop_front();
               check("pixel_out",      int'(pixel_out),      mon_e.pix);
               check("hcount_out",     int'(hcount_out),     mon_e.hx);
               check("vcount_out",     int'(vcount_out),     mon_e.vy);
               check("frame_done_out", int'(frame_done_out), mon_e.done);
               check("latency_cycle",  cycle,                mon_e.cyc);
            end
         end else begin
            check("frame_done_idle", int'(frame_done_out), 0);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int tx, ty;

      rst_in        = 1'b1;
      hcount_in     = '0;
      vcount_in     = '0;
      data_valid_in = 1'b0;
      pixel_in      = '0;
      mode_in       = 2'b00;
      threshold_in  = '0;
      for (int c = 0; c < GRID_W; c++) cnt[c] = 0;

      repeat (3) @(negedge clk_in);
      check("reset_pixel_out",      int'(pixel_out),      0);
      check("reset_hcount_out",     int'(hcount_out),     0);
      check("reset_vcount_out",     int'(vcount_out),     0);
      check("reset_data_valid_out", int'(data_valid_out), 0);
      check("reset_frame_done_out", int'(frame_done_out), 0);
      rst_in = 1'b0;
      repeat (2) @(negedge clk_in);

      // Full frame of a constant 0x40 in mean mode.
      mode_in = 2'b00;
      for (int v = 0; v < FRAME_H; v++)
         for (int h = 0; h < FRAME_W; h++)
            drive(h, v, 8'h40, 1'b1);

      // Ramp tile: mean of 0..63 is 2016>>6 = 31.
      mode_in = 2'b00;
      for (int k = 0; k < NPIX; k++) tile_pat[k] = k;
      drive_tile(0, 0);

      // Threshold 0x80 with a 0x7F tile and a 0x80 tile. The threshold input
      // changes mid-frame and must be ignored.
      mode_in      = 2'b01;
      threshold_in = 8'h80;
      for (int k = 0; k < NPIX; k++) tile_pat[k] = 8'h7F;
      drive_tile(0, 0);
      threshold_in = 8'hFF;
      mode_in      = 2'b00;
      for (int k = 0; k < NPIX; k++) tile_pat[k] = 8'h80;
      drive_tile(1, 0);

      // Ignored pixels interleaved with a mean tile. The values 32 + (k & 3)
      // give a mean of 33 and a min of 32.
      mode_in = 2'b00;
      for (int ly = 0; ly < BLK; ly++) begin
         for (int lx = 0; lx < BLK; lx++) begin
            drive(lx, ly, 32 + ((ly * BLK + lx) & 3), 1'b1);
            mode_in = 2'b11;
            drive(400, ly, 8'hFF, 1'b1);
            drive(lx, 250, 8'hFF, 1'b1);
            drive(lx, ly, 8'hFF, 1'b0);
            drive(0, 0, 8'hFF, 1'b0);
         end
      end
      drive(407, 7, 8'hFF, 1'b1);
      drive(7, 255, 8'hFF, 1'b1);

      // Randomized tiles: a random mode and threshold are set at the frame
      // origin, then a random tile is driven. That tile has junk pixels mixed
      // in, some pixels left out, and mode and threshold changing mid-frame.
      for (int it = 0; it < 30; it++) begin
         mode_in      = 2'($urandom_range(3));
         threshold_in = 8'($urandom_range(255));
         for (int k = 0; k < NPIX; k++) tile_pat[k] = $urandom_range(255);
         drive_tile(0, 0);
         tx = $urandom_range(GRID_W - 1);
         ty = $urandom_range(GRID_H - 1);
         for (int k = 0; k < NPIX; k++) begin
            mode_in      = 2'($urandom_range(3));
            threshold_in = 8'($urandom_range(255));
            if (k == 0 || k == NPIX - 1 || $urandom_range(7) != 0)
               drive(tx * BLK + k % BLK, ty * BLK + k / BLK, $urandom_range(255), 1'b1);
            if ($urandom_range(3) == 0) drive_junk();
         end
      end

      // Max then min. The tile is all 0x10 except 0xF0 at offset (3,5).
      for (int k = 0; k < NPIX; k++) tile_pat[k] = 8'h10;
      tile_pat[5 * BLK + 3] = 8'hF0;
      mode_in = 2'b10;
      drive_tile(0, 0);
      mode_in = 2'b11;
      drive_tile(2, 0);
      drive_tile(0, 0);
      drive_tile(3, 1);
      repeat (2) @(negedge clk_in);

      // Asynchronous reset after 20 pixels of tile (0,0), asserted mid-cycle.
      mode_in = 2'b00;
      for (int k = 0; k < 20; k++) drive(k % BLK, k / BLK, 8'hC0, 1'b1);
      #1 rst_in = 1'b1;
      #1;
      check("async_rst_pixel_out",      int'(pixel_out),      0);
      check("async_rst_hcount_out",     int'(hcount_out),     0);
      check("async_rst_vcount_out",     int'(vcount_out),     0);
      check("async_rst_data_valid_out", int'(data_valid_out), 0);
      check("async_rst_frame_done_out", int'(frame_done_out), 0);
      for (int c = 0; c < GRID_W; c++) cnt[c] = 0;
      m_mode = 0;
      m_thr  = 0;
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;

      // Resume from (0,0) with random data in mean mode.
      mode_in = 2'b00;
      for (int k = 0; k < NPIX; k++) tile_pat[k] = $urandom_range(255);
      drive_tile(0, 0);

      repeat (5) @(negedge clk_in);
      check("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_block_downsampler
